// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM controller: command codes, FSM states
// and status register bit positions.
package spi_pkg;
  localparam logic [7:0] CMD_LOAD_AR     = 8'h01;
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_STAT,
    ST_DROP
  } state_t;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_WRAP     = 1;
  localparam int STAT_CMD_ERR  = 2;
  localparam int STAT_CODE_LSB = 4;
endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte RAM, synchronous write, registered read (1 cycle), no reset.
// No backpressure: a read or write is accepted on every enabled edge.
module spi_ram_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              SCK,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge SCK) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// Byte-command SPI front end for a small RAM; tx_byte/tx_load follow a trigger by 1 cycle.
// No backpressure: every rx_valid is consumed or dropped on the edge it is sampled.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic       SCK,
  input  logic       reset,
  input  logic       SSB,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] status
);
  state_t            state;
  logic [ADDR_W-1:0] ar;
  logic              armed;
  logic              tx_from_mem;
  logic [7:0]        tx_reg;
  logic [7:0]        mem_rdata;
  logic              rx_ok;
  logic              mem_re;
  logic              mem_we;

  // A frame ending on the same edge as a byte always wins over that byte.
  assign rx_ok  = rx_valid && !SSB;
  assign mem_re = rx_ok && ((state == ST_CMD && rx_byte == CMD_READ) || state == ST_RD);
  assign mem_we = rx_ok && state == ST_WR;

  // Read data comes straight from the RAM output register, so it lines up
  // with tx_load one cycle after the trigger without a second pipeline stage.
  assign tx_byte = tx_from_mem ? mem_rdata : tx_reg;

  spi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .SCK   (SCK),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (ar),
    .wdata (rx_byte),
    .rdata (mem_rdata)
  );

  always_ff @(posedge SCK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ar          <= '0;
      armed       <= 1'b0;
      tx_reg      <= 8'h00;
      tx_from_mem <= 1'b0;
      tx_load     <= 1'b0;
      status      <= 8'h00;
    end else begin
      tx_load           <= 1'b0;
      status[STAT_BUSY] <= mem_we;
      if (SSB) armed <= 1'b1;

      if (mem_re || mem_we) begin
        ar <= ar + ADDR_W'(1);
        if (&ar) status[STAT_WRAP] <= 1'b1;
      end
      if (mem_re) begin
        tx_from_mem <= 1'b1;
        tx_load     <= 1'b1;
      end

      if (SSB) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (armed) state <= ST_CMD;
          ST_CMD: if (rx_valid) begin
            status[STAT_CODE_LSB +: 4] <= rx_byte[3:0];
            case (rx_byte)
              CMD_LOAD_AR: state <= ST_ADDR;
              CMD_WRITE:   state <= ST_WR;
              CMD_READ:    state <= ST_RD;
              CMD_READ_STATUS: begin
                state                 <= ST_STAT;
                tx_reg                <= status;
                tx_from_mem           <= 1'b0;
                tx_load               <= 1'b1;
                status[STAT_WRAP]     <= 1'b0;
                status[STAT_CMD_ERR]  <= 1'b0;
              end
              default: begin
                state                <= ST_DROP;
                status[STAT_CMD_ERR] <= 1'b1;
              end
            endcase
          end
          ST_ADDR: if (rx_valid) begin
            ar    <= ADDR_W'(rx_byte);
            state <= ST_DROP;
          end
          // Captures the pre-clear value; sticky flags drop on the same edge.
          ST_STAT: if (rx_valid) begin
            tx_reg               <= status;
            tx_from_mem          <= 1'b0;
            tx_load              <= 1'b1;
            status[STAT_WRAP]    <= 1'b0;
            status[STAT_CMD_ERR] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: load/write, read streaming, wrap/status,
// illegal command, frame abort and asynchronous reset.
module tb_spi_ram_ctrl;
  import spi_pkg::*;

  logic       SCK = 1'b0;
  logic       reset;
  logic       SSB;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] status;

  int checks = 0;
  int errors = 0;
  int busy_seen = 0;

  always #5 SCK = ~SCK;

  spi_ram_ctrl #(.ADDR_W(8)) dut (
    .SCK      (SCK),
    .reset    (reset),
    .SSB      (SSB),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load),
    .status   (status)
  );

  task automatic step();
    @(posedge SCK);
    #1;
    if (status[0]) busy_seen++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic frame_start();
    SSB = 1'b0;
    step();
  endtask

  task automatic frame_end();
    SSB = 1'b1;
    step();
  endtask

  task automatic load_ar(input logic [7:0] a);
    frame_start();
    send(CMD_LOAD_AR);
    send(a);
    frame_end();
  endtask

  task automatic test_reset();
    reset = 1'b1; SSB = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    step(); step();
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load got %b exp 0", tx_load); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", status); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state, ST_IDLE); end
    checks++; if (dut.ar !== 8'h00) begin errors++; $display("FAIL reset_ar got %h exp 00", dut.ar); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle_rx();
    send(CMD_READ);
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL idle_rx_tx_load got %b exp 0", tx_load); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL idle_rx_state got %0d exp %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_load_write();
    load_ar(8'h12);
    frame_start(); send(CMD_WRITE); send(8'h77); frame_end();
    load_ar(8'h10);
    busy_seen = 0;
    frame_start();
    send(CMD_WRITE);
    send(8'hAA);
    checks++; if (status[0] !== 1'b1) begin errors++; $display("FAIL wr_busy_set got %b exp 1", status[0]); end
    step();
    checks++; if (status[0] !== 1'b0) begin errors++; $display("FAIL wr_busy_one_cycle got %b exp 0", status[0]); end
    send(8'hBB);
    frame_end();
    checks++; if (busy_seen !== 2) begin errors++; $display("FAIL wr_busy_pulses got %0d exp 2", busy_seen); end
    checks++; if (dut.u_mem.mem[8'h10] !== 8'hAA) begin errors++; $display("FAIL wr_mem10 got %h exp AA", dut.u_mem.mem[8'h10]); end
    checks++; if (dut.u_mem.mem[8'h11] !== 8'hBB) begin errors++; $display("FAIL wr_mem11 got %h exp BB", dut.u_mem.mem[8'h11]); end
    checks++; if (dut.ar !== 8'h12) begin errors++; $display("FAIL wr_ar got %h exp 12", dut.ar); end
    checks++; if (status !== 8'h20) begin errors++; $display("FAIL wr_status got %h exp 20", status); end
  endtask

  task automatic test_read_stream();
    load_ar(8'h10);
    frame_start();
    send(CMD_READ);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'hAA) begin errors++; $display("FAIL rd_first got load=%b byte=%h exp load=1 byte=AA", tx_load, tx_byte); end
    step();
    checks++; if (tx_load !== 1'b0 || tx_byte !== 8'hAA) begin errors++; $display("FAIL rd_hold got load=%b byte=%h exp load=0 byte=AA", tx_load, tx_byte); end
    send(8'h00);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'hBB) begin errors++; $display("FAIL rd_second got load=%b byte=%h exp load=1 byte=BB", tx_load, tx_byte); end
    send(8'h00);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'h77) begin errors++; $display("FAIL rd_third got load=%b byte=%h exp load=1 byte=77", tx_load, tx_byte); end
    frame_end();
    checks++; if (dut.ar !== 8'h13) begin errors++; $display("FAIL rd_ar got %h exp 13", dut.ar); end
  endtask

  task automatic test_wrap_status();
    load_ar(8'hFF);
    frame_start(); send(CMD_WRITE); send(8'h5C); send(8'h5D); frame_end();
    checks++; if (dut.u_mem.mem[8'hFF] !== 8'h5C) begin errors++; $display("FAIL wrap_memFF got %h exp 5C", dut.u_mem.mem[8'hFF]); end
    checks++; if (dut.u_mem.mem[8'h00] !== 8'h5D) begin errors++; $display("FAIL wrap_mem00 got %h exp 5D", dut.u_mem.mem[8'h00]); end
    checks++; if (dut.ar !== 8'h01) begin errors++; $display("FAIL wrap_ar got %h exp 01", dut.ar); end
    checks++; if (status !== 8'h22) begin errors++; $display("FAIL wrap_status got %h exp 22", status); end
    frame_start();
    send(CMD_READ_STATUS);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'h22) begin errors++; $display("FAIL stat_first got load=%b byte=%h exp load=1 byte=22", tx_load, tx_byte); end
    step();
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL stat_load_pulse got %b exp 0", tx_load); end
    send(8'h00);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'h50) begin errors++; $display("FAIL stat_second got load=%b byte=%h exp load=1 byte=50", tx_load, tx_byte); end
    frame_end();
  endtask

  task automatic test_illegal();
    load_ar(8'h11);
    frame_start();
    send(8'h07);
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL ill_load_cmd got %b exp 0", tx_load); end
    send(8'h33);
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL ill_load_data got %b exp 0", tx_load); end
    checks++; if (dut.state !== ST_DROP) begin errors++; $display("FAIL ill_state got %0d exp %0d", dut.state, ST_DROP); end
    frame_end();
    checks++; if (status !== 8'h74) begin errors++; $display("FAIL ill_status got %h exp 74", status); end
    checks++; if (dut.ar !== 8'h11) begin errors++; $display("FAIL ill_ar got %h exp 11", dut.ar); end
    checks++; if (dut.u_mem.mem[8'h11] !== 8'hBB) begin errors++; $display("FAIL ill_mem11 got %h exp BB", dut.u_mem.mem[8'h11]); end
  endtask

  task automatic test_abort();
    load_ar(8'h20);
    frame_start(); send(CMD_WRITE); send(8'h00); send(8'h99); frame_end();
    load_ar(8'h20);
    frame_start();
    send(CMD_WRITE);
    send(8'h41);
    SSB = 1'b1; rx_valid = 1'b1; rx_byte = 8'h42;
    step();
    rx_valid = 1'b0;
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL abort_state got %0d exp %0d", dut.state, ST_IDLE); end
    checks++; if (dut.u_mem.mem[8'h20] !== 8'h41) begin errors++; $display("FAIL abort_mem20 got %h exp 41", dut.u_mem.mem[8'h20]); end
    checks++; if (dut.u_mem.mem[8'h21] !== 8'h99) begin errors++; $display("FAIL abort_mem21 got %h exp 99", dut.u_mem.mem[8'h21]); end
    checks++; if (dut.ar !== 8'h21) begin errors++; $display("FAIL abort_ar got %h exp 21", dut.ar); end
    checks++; if (status[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", status[0]); end
  endtask

  task automatic test_reset_mid_read();
    load_ar(8'h10);
    frame_start();
    send(CMD_READ);
    checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL rst_pre_load got %b exp 1", tx_load); end
    reset = 1'b1;
    #1;
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_async_load got %b exp 0", tx_load); end
    checks++; if (dut.ar !== 8'h00) begin errors++; $display("FAIL rst_async_ar got %h exp 00", dut.ar); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_async_state got %0d exp %0d", dut.state, ST_IDLE); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_async_tx_byte got %h exp 00", tx_byte); end
    step();
    reset = 1'b0;
    step(); step(); step();
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_needs_ssb got %0d exp %0d", dut.state, ST_IDLE); end
    SSB = 1'b1;
    step();
    frame_start();
    checks++; if (dut.state !== ST_CMD) begin errors++; $display("FAIL rst_rearm got %0d exp %0d", dut.state, ST_CMD); end
    frame_end();
  endtask

  initial begin
    test_reset();
    test_idle_rx();
    test_load_write();
    test_read_stream();
    test_wrap_status();
    test_illegal();
    test_abort();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, address width; memory depth is 2**ADDR_W bytes.
REQ-002 Port: SCK, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-high reset.
REQ-004 Port: SSB, input, 1, active-low frame select; high means no frame is active.
REQ-005 Port: rx_valid, input, 1, one-cycle pulse indicating that a complete byte has been received from the SPI slave shifter.
REQ-006 Port: rx_byte, input, 8, received byte, qualified by rx_valid.
REQ-007 Port: tx_byte, output, 8, next byte for the slave to shift out on MISO.
REQ-008 Port: tx_load, output, 1, one-cycle pulse indicating that tx_byte is new and must be loaded into the slave shift register.
REQ-009 Port: status, output, 8, status register: bit0 busy, bit1 wrap, bit2 cmd_err, bits7:4 last command code.

Function
REQ-010 Command codes: 0x01 LOAD_AR; 0x02 WRITE; 0x03 READ; 0x05 READ_STATUS. All other codes are illegal.
REQ-011 FSM states: IDLE, CMD, ADDR, WR, RD, STAT, DROP.
REQ-012 FSM transitions:
- IDLE -> CMD when SSB=0.
- CMD on rx_valid: 0x01 -> ADDR; 0x02 -> WR; 0x03 -> RD; 0x05 -> STAT; illegal code -> DROP.
REQ-013 On rx_valid in CMD, bits7:4 of status take rx_byte[3:0].
REQ-014 An illegal command sets cmd_err.
REQ-015 ADDR: the first rx_valid loads AR <= rx_byte[ADDR_W-1:0]; the state then moves to DROP.
REQ-016 WR: each rx_valid writes mem[AR] <= rx_byte and increments AR, both on the same edge.
REQ-017 busy is high for exactly the one cycle following each WR-state rx_valid.
REQ-018 RD entry: on the command edge, the block issues a read of mem[AR]; tx_byte = mem[AR] and tx_load=1 one cycle later (latency 1), and AR is incremented.
REQ-019 RD streaming: each further rx_valid (dummy byte) repeats the REQ-018 read/present/increment with the same 1-cycle latency.
REQ-020 STAT: on the command edge, the block sets tx_byte <= status (value before any clear) and pulses tx_load one cycle later.
REQ-021 STAT clear: wrap and cmd_err clear on the same edge that captures status into tx_byte.
REQ-022 STAT repeats the capture on every further rx_valid.
REQ-023 DROP ignores all rx_valid pulses until the frame ends.
REQ-024 AR width is ADDR_W. Increment from 2**ADDR_W-1 wraps to 0 and sets wrap, which is sticky until a status read.
REQ-025 SSB=1 in any non-IDLE state returns the FSM to IDLE on the next edge. Any partial byte is abandoned. AR, mem and status flags are retained.
REQ-026 rx_valid together with SSB=1 on the same edge: SSB wins; no write or increment occurs.
REQ-027 tx_load is 0 in every cycle not named above.
REQ-028 tx_byte holds its last value between tx_load pulses.
REQ-029 If rx_valid arrives in IDLE, it is ignored.

Reset
REQ-030 reset asserts asynchronously to: FSM=IDLE, AR=0, tx_byte=0x00, tx_load=0, status=0x00.
REQ-031 Memory contents are not reset.
REQ-032 reset mid-frame aborts the frame immediately.
REQ-033 After reset deasserts, the block needs SSB=1 before a new frame is accepted.

Structure
REQ-034 A shared package spi_pkg shall hold the command code constants, the FSM state enum type, and the status bit index constants.
REQ-035 Storage shall be the sub-module spi_ram_mem: single-port, synchronous write, registered read, depth 2**ADDR_W x 8, on SCK.
REQ-036 spi_ram_mem shall have no reset.

Verification
REQ-037 Load and write: frame [0x01,0x10], then frame [0x02,0xAA,0xBB] -> mem[0x10]=0xAA, mem[0x11]=0xBB, AR=0x12, busy pulses twice.
REQ-038 Read stream: after REQ-037, LOAD_AR 0x10 then frame [0x03,dummy,dummy] -> tx_byte 0xAA, 0xBB, then mem[0x12], each 1 cycle after its trigger with tx_load.
REQ-039 Wrap: LOAD_AR 0xFF, WRITE [0x5C,0x5D] -> mem[0xFF]=0x5C, mem[0x00]=0x5D, wrap=1. Then READ_STATUS -> tx_byte bit1=1 and bits7:4=0x2; a second status read returns bit1=0.
REQ-040 Illegal command: frame [0x07,0x33] -> no memory change, cmd_err=1, AR unchanged, tx_load stays 0.
REQ-041 Abort: WRITE frame with SSB raised on the same edge as the second rx_valid -> only the first byte is written, FSM=IDLE next cycle.
REQ-042 Reset: reset asserted mid-READ -> tx_load=0, AR=0, FSM=IDLE immediately, without waiting for an SCK edge.
